uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter SAMPLES_PER_BIT, default 16: Tx_sample_ENABLE pulses per transmitted bit.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 Tx_sample_ENABLE  input  1  one-clk pulse at SAMPLES_PER_BIT x baud rate, from baud generator.
REQ-005 Tx_EN  input  1  transmitter enable; gates acceptance of new frames only.
REQ-006 Tx_WR  input  1  one-clk write strobe; requests transmission of Tx_DATA.
REQ-007 Tx_DATA  input  8  byte to send; sampled only on an accepted Tx_WR.
REQ-008 TxD  output  1  serial line; idle high.
REQ-009 Tx_BUSY  output  1  high from acceptance until frame end.

Function
REQ-010 Accept: Tx_WR=1 and Tx_EN=1 and Tx_BUSY=0 at a clk edge latches Tx_DATA into an internal shift register; Tx_BUSY=1 from the next cycle.
REQ-011 Tx_WR when Tx_BUSY=1 or Tx_EN=0 shall be ignored; latched byte and frame unaffected.
REQ-012 FSM states: IDLE, START, DATA, PARITY, STOP; IDLE->START on accept; START->DATA, DATA->PARITY (after bit 7), PARITY->STOP, STOP->IDLE, each on the SAMPLES_PER_BIT-th enable pulse of the current bit.
REQ-013 TxD per state: IDLE 1, START 0, DATA current bit (LSB first, bit 0..7), PARITY even parity (XOR of the 8 latched bits), STOP 1; TxD registered.
REQ-014 Bit timing: internal counter of width ceil(log2(SAMPLES_PER_BIT)) increments only on Tx_sample_ENABLE; bit advances and counter wraps to 0 when counter=SAMPLES_PER_BIT-1 with Tx_sample_ENABLE=1.
REQ-015 Sample counter and 3-bit data-bit index shall be cleared on accept, so each frame starts bit-aligned.
REQ-016 Frame length: 11 bits (with parity) = 11*SAMPLES_PER_BIT enable pulses, 176 at default.
REQ-017 Tx_BUSY shall fall on the cycle after the final STOP enable pulse; TxD stays 1.
REQ-018 Back-to-back: an accepted Tx_WR in the first cycle with Tx_BUSY=0 starts the next frame; no extra idle bit required.
REQ-019 Tx_EN deasserted mid-frame: current frame completes unchanged.
REQ-020 No Tx_sample_ENABLE pulses: FSM and TxD hold indefinitely.

Reset
REQ-021 reset=0 at a clk edge: state IDLE, TxD=1, Tx_BUSY=0, counters and shift register 0; overrides every other input.
REQ-022 reset mid-frame aborts the frame; first cycle after release TxD=1, Tx_BUSY=0; no partial bit resumed.

Configuration
REQ-023 Macro UART_TX_PARITY_EN defined: PARITY state present, 11-bit frame as REQ-012..016.
REQ-024 UART_TX_PARITY_EN undefined: PARITY state and parity logic removed, DATA->STOP directly, 10-bit frame (160 pulses at default); all other behaviour identical.

Verification
REQ-025 Reset: hold reset=0 3 cycles with Tx_WR=1 -> TxD=1, Tx_BUSY=0 throughout and after release.
REQ-026 Single frame, Tx_DATA=8'hA5, enable every 4 clk -> TxD per bit: 0,1,0,1,0,0,1,0,1,0,1 (parity 0), each held 16 pulses; Tx_BUSY high exactly 176 pulses.
REQ-027 Tx_DATA=8'h01 -> parity bit 1; with UART_TX_PARITY_EN undefined -> 10 bits 0,1,0,0,0,0,0,0,0,1, 160 pulses.
REQ-028 Tx_WR with Tx_DATA=8'hFF during busy frame 8'h3C -> 8'h3C sent intact, 8'hFF never sent; Tx_WR with Tx_EN=0 -> Tx_BUSY stays 0.
REQ-029 Back-to-back 8'h55 then 8'hAA, second Tx_WR on first cycle Tx_BUSY=0 -> stop bit of first immediately followed by start bit of second, no idle gap.
REQ-030 reset=0 during DATA bit 3 of 8'hF0 -> next cycle TxD=1, Tx_BUSY=0; subsequent Tx_WR of 8'h0F transmits a clean full frame.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter: start, LSB-first data, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to include the parity bit (11-bit frame); otherwise 10-bit frame.
module uart_transmitter #(
  parameter int SAMPLES_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tx_sample_ENABLE,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY
);

  localparam int CW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            accept;
  logic            bit_end;

  assign accept  = Tx_WR && Tx_EN && !busy_q;
  assign bit_end = Tx_sample_ENABLE && (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, bit timing and registered line value derived from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    txd_d   = 1'b1;
    busy_d  = 1'b0;

    if (state_q != IDLE && Tx_sample_ENABLE)
      cnt_d = bit_end ? '0 : CW'(cnt_q + 1'b1);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          data_d  = Tx_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            bit_d = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = ^data_q;
`endif
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter; enable pulse every 4 clocks, SAMPLES_PER_BIT=16.
module tb_uart_transmitter;

  localparam int SPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Tx_sample_ENABLE = 1'b0;
  logic       Tx_EN = 1'b1;
  logic       Tx_WR = 1'b0;
  logic [7:0] Tx_DATA = 8'h00;
  logic       TxD;
  logic       Tx_BUSY;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.SAMPLES_PER_BIT(SPB)) dut (
    .clk              (clk),
    .reset            (reset),
    .Tx_sample_ENABLE (Tx_sample_ENABLE),
    .Tx_EN            (Tx_EN),
    .Tx_WR            (Tx_WR),
    .Tx_DATA          (Tx_DATA),
    .TxD              (TxD),
    .Tx_BUSY          (Tx_BUSY)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are always changed 1 time unit after a rising edge.
  task automatic cyc(input logic e);
    Tx_sample_ENABLE = e;
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain, 1: stray write of 8'hFF mid-frame, 2: Tx_EN dropped mid-frame
  task automatic run_frame(input string nm, input logic [7:0] d,
                           input logic [10:0] e11, input logic [9:0] e10, input int mode);
    logic [10:0] cap;
    logic [10:0] ex;
    logic        ok;
    int          nb;
`ifdef UART_TX_PARITY_EN
    nb = 11; ex = e11;
`else
    nb = 10; ex = {1'b0, e10};
`endif
    chk({nm, "_pre_busy"}, Tx_BUSY, 1'b0);
    chk({nm, "_pre_txd"}, TxD, 1'b1);
    Tx_WR = 1'b1; Tx_DATA = d;
    cyc(1'b0);
    Tx_WR = 1'b0; Tx_DATA = 8'h00;
    chk({nm, "_acc_busy"}, Tx_BUSY, 1'b1);
    chk({nm, "_acc_start"}, TxD, 1'b0);
    cap = '0;
    for (int b = 0; b < nb; b++) begin
      ok = 1'b1;
      for (int p = 0; p < SPB; p++) begin
        for (int k = 0; k < 4; k++) begin
          if (p == 0 && k == 0) cap = {cap[9:0], TxD};
          ok = ok && (TxD === ex[nb-1-b]) && (Tx_BUSY === 1'b1);
          Tx_WR   = (mode == 1 && b == 4 && p == 3 && k == 0);
          Tx_DATA = Tx_WR ? 8'hFF : 8'h00;
          if (mode == 2 && b == 2) Tx_EN = 1'b0;
          cyc(k == 3);
        end
      end
      chk($sformatf("%s_bit%0d_held", nm, b), {15'd0, ok}, 16'd1);
    end
    Tx_WR = 1'b0; Tx_DATA = 8'h00; Tx_EN = 1'b1;
    chk({nm, "_frame"}, {5'd0, cap}, {5'd0, ex});
    chk({nm, "_end_busy"}, Tx_BUSY, 1'b0);
    chk({nm, "_end_txd"}, TxD, 1'b1);
  endtask

  initial begin
    // reset held 3 cycles while a write is requested
    #1;
    reset = 1'b0; Tx_WR = 1'b1; Tx_EN = 1'b1; Tx_DATA = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk($sformatf("rst%0d_txd", i), TxD, 1'b1);
      chk($sformatf("rst%0d_busy", i), Tx_BUSY, 1'b0);
    end
    Tx_WR = 1'b0; reset = 1'b1;
    cyc(1'b0);
    chk("rel_txd", TxD, 1'b1);
    chk("rel_busy", Tx_BUSY, 1'b0);

    // no pulses: idle holds
    for (int i = 0; i < 5; i++) cyc(1'b0);
    chk("hold_txd", TxD, 1'b1);

    run_frame("a5", 8'hA5, 11'b01010010101, 10'b0101001011, 0);
    run_frame("01", 8'h01, 11'b01000000011, 10'b0100000001, 0);

    // write while disabled is ignored
    Tx_EN = 1'b0; Tx_WR = 1'b1; Tx_DATA = 8'h77;
    cyc(1'b0);
    chk("dis_busy0", Tx_BUSY, 1'b0);
    Tx_WR = 1'b0;
    cyc(1'b1);
    chk("dis_busy1", Tx_BUSY, 1'b0);
    chk("dis_txd", TxD, 1'b1);
    Tx_EN = 1'b1;

    run_frame("3c", 8'h3C, 11'b00011110001, 10'b0001111001, 1);
    cyc(1'b0);
    chk("3c_no_ff_busy", Tx_BUSY, 1'b0);

    // back-to-back: second accept on first not-busy cycle
    run_frame("55", 8'h55, 11'b01010101001, 10'b0101010101, 0);
    run_frame("aa", 8'hAA, 11'b00101010101, 10'b0010101011, 2);

    // reset during data bit 3 of 8'hF0
    Tx_WR = 1'b1; Tx_DATA = 8'hF0;
    cyc(1'b0);
    Tx_WR = 1'b0;
    for (int p = 0; p < 4 * SPB + 2; p++) begin
      cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
    end
    chk("f0_mid_txd", TxD, 1'b0);
    chk("f0_mid_busy", Tx_BUSY, 1'b1);
    reset = 1'b0;
    cyc(1'b1);
    chk("f0_rst_txd", TxD, 1'b1);
    chk("f0_rst_busy", Tx_BUSY, 1'b0);
    reset = 1'b1;
    cyc(1'b1);
    chk("f0_rel_txd", TxD, 1'b1);
    chk("f0_rel_busy", Tx_BUSY, 1'b0);

    run_frame("0f", 8'h0F, 11'b01111000001, 10'b0111100001, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
